// File: rtl/pipe_muxn_if.sv
// pipe_muxn_if: channel-side and output-side handshake bundle for pipe_muxn.
interface pipe_muxn_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned N     = 4,
   parameter int unsigned SEL_W = 2
) ();
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic               mode;
   logic [SEL_W-1:0]   s;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic [SEL_W-1:0]   grant;

   modport master (
      output in_data, in_valid, mode, s, out_ready,
      input  in_ready, out_data, out_valid, grant
   );

   modport slave (
      input  in_data, in_valid, mode, s, out_ready,
      output in_ready, out_data, out_valid, grant
   );
endinterface

// File: rtl/pipe_muxn.sv
// pipe_muxn: N-channel mux feeding a single-entry output register.
// mode 0 selects channel s; mode 1 arbitrates round-robin from an internal pointer.
module pipe_muxn #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned N     = 4,
   parameter int unsigned SEL_W = 2
) (
   input logic        clk,
   input logic        rst,
   pipe_muxn_if.slave bus
);
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_valid;
   logic [SEL_W-1:0] r_grant;
   logic [SEL_W-1:0] r_rr_ptr;

   logic             w_load_en;
   logic             w_rr_found;
   logic [SEL_W-1:0] w_rr_win;
   logic             w_cand_ok;
   logic [SEL_W-1:0] w_cand;
   logic [N-1:0]     w_in_ready;
   logic [WIDTH-1:0] w_sel_data;
   logic             w_xfer;
   logic [SEL_W-1:0] w_rr_next;

   assign w_load_en = !r_out_valid || bus.out_ready;

   // Round-robin winner: valid channel with the smallest circular distance from r_rr_ptr.
   always_comb begin
      int unsigned v_dist;
      int unsigned v_best;
      w_rr_found = 1'b0;
      w_rr_win   = '0;
      v_dist     = 0;
      v_best     = N;
      for (int unsigned k = 0; k < N; k++) begin
         if (k >= 32'(r_rr_ptr)) v_dist = k - 32'(r_rr_ptr);
         else                    v_dist = k + N - 32'(r_rr_ptr);
         if (bus.in_valid[k] && (v_dist < v_best)) begin
            v_best     = v_dist;
            w_rr_win   = SEL_W'(k);
            w_rr_found = 1'b1;
         end
      end
   end

   // Candidate channel: s in fixed mode (only if in range), round-robin winner otherwise.
   always_comb begin
      w_cand    = '0;
      w_cand_ok = 1'b0;
      if (bus.mode) begin
         w_cand    = w_rr_win;
         w_cand_ok = w_rr_found;
      end else if (32'(bus.s) < N) begin
         w_cand    = bus.s;
         w_cand_ok = 1'b1;
      end
   end

   // Ready goes only to the candidate; data mux is independent of out_data.
   always_comb begin
      w_in_ready = '0;
      w_sel_data = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (w_cand == SEL_W'(k)) begin
            w_in_ready[k] = w_cand_ok && w_load_en && !rst;
            w_sel_data    = bus.in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   assign w_xfer    = |(w_in_ready & bus.in_valid);
   assign w_rr_next = (32'(w_cand) == N - 1) ? '0 : w_cand + SEL_W'(1);

   // Output register and round-robin pointer; a transfer wins over a plain pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_grant     <= '0;
         r_rr_ptr    <= '0;
      end else if (w_xfer) begin
         r_out_data  <= w_sel_data;
         r_grant     <= w_cand;
         r_out_valid <= 1'b1;
         if (bus.mode) r_rr_ptr <= w_rr_next;
      end else if (r_out_valid && bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_data  = r_out_data;
   assign bus.out_valid = r_out_valid;
   assign bus.grant     = r_grant;
endmodule

// File: doc/pipe_muxn.md
PIPE_MUXN -- requirements
Module: pipe_muxn

Interface
REQ-001 Parameter WIDTH, default 16, data width of each input channel and the output.
REQ-002 Parameter N, default 4, number of input channels (2..16).
REQ-003 Parameter SEL_W, default 2, width of select/grant fields; SHALL equal ceil(log2(N)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_data  input  N*WIDTH  packed channel data; channel k at bits [k*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  per-channel valid.
REQ-008 in_ready  output  N  per-channel ready; combinational.
REQ-009 mode  input  1  0 = fixed select by s, 1 = round-robin arbitration.
REQ-010 s  input  SEL_W  channel select, used only when mode = 0.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  out_data holds an unconsumed word.
REQ-013 out_ready  input  1  downstream accepts out_data this cycle.
REQ-014 grant  output  SEL_W  registered index of the channel whose word is in out_data.

Function
REQ-015 Single-entry output register; load_en = !out_valid || out_ready.
REQ-016 Transfer on channel k SHALL occur in a cycle where in_valid[k] && in_ready[k]; at most one channel transfers per cycle.
REQ-017 On transfer, next edge: out_data <= channel k data, grant <= k, out_valid <= 1; latency exactly 1 cycle.
REQ-018 Output pop (out_valid && out_ready) with no transfer same cycle -> out_valid <= 0; out_data and grant hold last values.
REQ-019 Simultaneous pop and transfer -> new word loaded, out_valid stays 1 (full throughput, one word per cycle).
REQ-020 While out_valid && !out_ready: out_data, grant, out_valid SHALL hold; all in_ready = 0.
REQ-021 mode 0: in_ready[s] = load_en, all other in_ready = 0; in_valid of unselected channels ignored.
REQ-022 mode 0 with s >= N: all in_ready = 0, no transfer.
REQ-023 mode 1: internal pointer rr_ptr (SEL_W bits); winner = first k with in_valid[k] set, searching rr_ptr, rr_ptr+1, ... modulo N; in_ready[winner] = load_en, others 0.
REQ-024 mode 1 transfer on channel k -> rr_ptr <= (k+1) mod N; wraps N-1 -> 0; no transfer -> rr_ptr holds.
REQ-025 mode 0 transfers SHALL NOT alter rr_ptr.
REQ-026 No in_valid set (mode 1) or in_valid[s] = 0 (mode 0) -> no transfer, all in_ready follow REQ-021/023 only for the candidate.
REQ-027 mode or s changes take effect same cycle for in_ready; a word already in out_data SHALL be unaffected.
REQ-028 in_ready SHALL NOT depend combinationally on out_data; it may depend on out_ready, in_valid, mode, s, rr_ptr, out_valid.

Reset
REQ-029 rst = 1 at a rising edge -> out_valid = 0, out_data = 0, grant = 0, rr_ptr = 0 after that edge.
REQ-030 Reset mid-operation SHALL discard any held word; all in_ready = 0 during the reset cycle.
REQ-031 First transfer possible in the first cycle with rst = 0.

Verification
REQ-032 Fixed select: mode 0, ch0..3 = ABCD/0123/0000/4567, all valid, out_ready = 1, s stepped 0,1,2,3,0 one per cycle -> out_data ABCD,0123,0000,4567,ABCD, each one cycle after its s, grant matches.
REQ-033 Round-robin: mode 1, all 4 valid, out_ready = 1 -> grants 0,1,2,3,0,1 on consecutive cycles, out_valid continuously 1.
REQ-034 Backpressure: hold word 0123 (grant 1), out_ready = 0 for 3 cycles -> out_data/grant unchanged, in_ready = 0000; out_ready = 1 -> next word loads following edge.
REQ-035 Sparse RR: mode 1, rr_ptr = 2, only in_valid[1] set -> grant 1, rr_ptr becomes 2; then only ch3 and ch0 valid -> grant 3 then 0 (wrap).
REQ-036 Out-of-range/empty: N = 3 instance, mode 0, s = 3 -> in_ready = 000, out_valid stays 0; rst asserted while out_valid = 1 -> out_valid = 0, out_data = 0, grant = 0 next edge.
